// File: rtl/mac_tx_pkg.sv
// Shared types and encodings for the MAC transmit streamer.
package mac_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StSend
  } state_e;

  localparam int unsigned LaneW = 2;
  typedef logic [LaneW-1:0] lane_t;

  typedef logic [10:0] len_t;

  // Count of invalid trailing bytes in the eop word.
  localparam logic [1:0] MOD_4B = 2'd0;
  localparam logic [1:0] MOD_3B = 2'd1;
  localparam logic [1:0] MOD_2B = 2'd2;
  localparam logic [1:0] MOD_1B = 2'd3;

  // Abort closes a word holding 'lane' bytes; an empty word still reports MOD_1B.
  function automatic logic [1:0] abort_mod(input lane_t lane);
    logic [2:0] invalid;
    invalid = 3'd4 - {1'b0, lane};
    return (lane == '0) ? MOD_1B : invalid[1:0];
  endfunction

endpackage

// File: rtl/mac_tx_byte_packer.sv
// Packs bytes big-endian into a 32-bit word and computes close/eop/mod for each word.
module mac_tx_byte_packer
  import mac_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  input  logic        abort_i,
  output logic        close_o,
  output logic [31:0] word_o,
  output logic        eop_o,
  output logic        err_o,
  output logic [1:0]  mod_o
);

  lane_t       lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic        eop_q, eop_d;
  logic        err_q, err_d;
  logic [1:0]  mod_q, mod_d;

  assign close_o = byte_en_i && ((lane_q == 2'd3) || last_i);

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    eop_d  = eop_q;
    err_d  = err_q;
    mod_d  = mod_q;
    if (clear_i) begin
      lane_d = '0;
      word_d = '0;
      eop_d  = 1'b0;
      err_d  = 1'b0;
      mod_d  = MOD_4B;
    end else if (abort_i) begin
      eop_d = 1'b1;
      err_d = 1'b1;
      mod_d = abort_mod(lane_q);
    end else if (byte_en_i) begin
      // Lane 0 is the most significant byte.
      word_d[8*(3-int'(lane_q)) +: 8] = byte_i;
      lane_d = lane_q + 2'd1;
      if (close_o) begin
        eop_d = last_i;
        mod_d = last_i ? (2'd3 - lane_q) : MOD_4B;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q <= '0;
      word_q <= '0;
      eop_q  <= 1'b0;
      err_q  <= 1'b0;
      mod_q  <= MOD_4B;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      eop_q  <= eop_d;
      err_q  <= err_d;
      mod_q  <= mod_d;
    end
  end

  assign word_o = word_q;
  assign eop_o  = eop_q;
  assign err_o  = err_q;
  assign mod_o  = mod_q;

endmodule

// File: rtl/mac_tx_streamer.sv
// Byte-stream to MAC ff_tx word source with sop/eop/mod and backpressure.
// Optional underrun abort enabled by defining MAC_TX_ERR_EN.
module mac_tx_streamer
  import mac_tx_pkg::*;
#(
  parameter int unsigned UNDERRUN_CYCLES = 256
) (
  input  logic        ff_tx_clk,
  input  logic        reset,
  input  logic [10:0] pkt_len,
  input  logic        pkt_start,
  output logic        pkt_busy,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] ff_tx_data,
  output logic        ff_tx_sop,
  output logic        ff_tx_eop,
  output logic        ff_tx_err,
  output logic [1:0]  ff_tx_mod,
  output logic        ff_tx_wren,
  input  logic        ff_tx_rdy
);

  state_e state_q, state_d;
  len_t   remain_q, remain_d;
  logic   first_q, first_d;

  logic        start, accept, xfer, abort, send;
  logic        pk_close, pk_eop, pk_err;
  logic [31:0] pk_word;
  logic [1:0]  pk_mod;

  assign start  = (state_q == StIdle) && pkt_start && (pkt_len != '0);
  assign accept = (state_q == StFill) && in_valid;
  assign send   = (state_q == StSend);
  assign xfer   = send && ff_tx_rdy;

`ifdef MAC_TX_ERR_EN
  localparam int unsigned CntW = $clog2(UNDERRUN_CYCLES + 1);
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

  // Counts consecutive starved FILL cycles; any accepted byte restarts it.
  assign abort = (state_q == StFill) && !in_valid &&
                 (idle_cnt_q == CntW'(UNDERRUN_CYCLES - 1));

  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == StFill) && !in_valid && !abort) begin
      idle_cnt_d = idle_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge ff_tx_clk) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign ff_tx_err = send & pk_err;
`else
  logic unused_err;
  assign unused_err = pk_err ^ (^UNDERRUN_CYCLES);
  assign abort      = 1'b0;
  assign ff_tx_err  = 1'b0;
`endif

  mac_tx_byte_packer u_packer (
    .clk_i     (ff_tx_clk),
    .rst_i     (reset),
    .clear_i   (start | xfer),
    .byte_en_i (accept),
    .byte_i    (in_data),
    .last_i    (remain_q == 11'd1),
    .abort_i   (abort),
    .close_o   (pk_close),
    .word_o    (pk_word),
    .eop_o     (pk_eop),
    .err_o     (pk_err),
    .mod_o     (pk_mod)
  );

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    first_d  = first_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          remain_d = pkt_len;
          first_d  = 1'b1;
          state_d  = StFill;
        end
      end
      StFill: begin
        if (accept) begin
          remain_d = remain_q - 11'd1;
        end
        if (pk_close || abort) begin
          state_d = StSend;
        end
      end
      StSend: begin
        if (ff_tx_rdy) begin
          first_d = 1'b0;
          state_d = pk_eop ? StIdle : StFill;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ff_tx_clk) begin
    if (reset) begin
      state_q  <= StIdle;
      remain_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      first_q  <= first_d;
    end
  end

  assign pkt_busy   = (state_q != StIdle);
  assign in_ready   = (state_q == StFill);
  assign ff_tx_wren = send;
  assign ff_tx_data = send ? pk_word : '0;
  assign ff_tx_sop  = send & first_q;
  assign ff_tx_eop  = send & pk_eop;
  assign ff_tx_mod  = send ? pk_mod : MOD_4B;

endmodule

// File: tb/tb_mac_tx_streamer.sv
// Self-checking bench for mac_tx_streamer against a word-list reference model.
module tb_mac_tx_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] pkt_len;
  logic        pkt_start;
  logic        pkt_busy;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ff_tx_data;
  logic        ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_wren, ff_tx_rdy;
  logic [1:0]  ff_tx_mod;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
  } word_t;

  int    n_checks = 0;
  int    n_err    = 0;
  logic [7:0] bytes_q[$];
  word_t exp_q[$];
  word_t got_q[$];

  mac_tx_streamer #(.UNDERRUN_CYCLES(8)) dut (
    .ff_tx_clk  (clk),
    .reset      (reset),
    .pkt_len    (pkt_len),
    .pkt_start  (pkt_start),
    .pkt_busy   (pkt_busy),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ff_tx_data (ff_tx_data),
    .ff_tx_sop  (ff_tx_sop),
    .ff_tx_eop  (ff_tx_eop),
    .ff_tx_err  (ff_tx_err),
    .ff_tx_mod  (ff_tx_mod),
    .ff_tx_wren (ff_tx_wren),
    .ff_tx_rdy  (ff_tx_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the packet is ceil(n/4) big-endian words, zero padded.
  function automatic void build_expected();
    int n;
    int nw;
    n  = bytes_q.size();
    nw = (n + 3) / 4;
    exp_q.delete();
    for (int w = 0; w < nw; w++) begin
      word_t e;
      e.data = '0;
      for (int b = 0; b < 4; b++) begin
        if (4*w + b < n) e.data[31-8*b -: 8] = bytes_q[4*w+b];
      end
      e.sop = (w == 0);
      e.eop = (w == nw - 1);
      e.mod = e.eop ? 2'((4 - n % 4) % 4) : 2'd0;
      exp_q.push_back(e);
    end
  endfunction

  function automatic word_t cur_word();
    word_t c;
    c.data = ff_tx_data;
    c.sop  = ff_tx_sop;
    c.eop  = ff_tx_eop;
    c.mod  = ff_tx_mod;
    return c;
  endfunction

  // mode 0: continuous; 1: random valid/rdy; 2: stall second word for 3 cycles.
  task automatic run_pkt(input int mode, input bit abort_first);
    int    n, idx, cyc, stall_cnt, idle_run;
    bit    done, prev_stall, exp_wren;
    word_t cur, prev_w;
    n = bytes_q.size();
    idx = 0; cyc = 0; stall_cnt = 0; idle_run = 0;
    done = 0; prev_stall = 0; exp_wren = 0;
    prev_w = '0;
    build_expected();
    got_q.delete();
    @(negedge clk);
    pkt_len   = 11'(n);
    pkt_start = 1'b1;
    @(negedge clk);
    pkt_start = 1'b0;
    chk("busy_after_start", 64'(pkt_busy), 64'd1);
    chk("in_ready_after_start", 64'(in_ready), 64'd1);
    while (!done && cyc < 20000) begin
      cur = cur_word();
      if (prev_stall) begin
        chk("hold_wren", 64'(ff_tx_wren), 64'd1);
        chk("hold_word", 64'(cur), 64'(prev_w));
      end
      if (exp_wren) chk("wren_after_close", 64'(ff_tx_wren), 64'd1);
      chk("ready_vs_wren", 64'(in_ready), 64'(!ff_tx_wren));
      chk("err_low", 64'(ff_tx_err), 64'd0);
      case (mode)
        0: begin
          in_valid  = 1'b1;
          ff_tx_rdy = 1'b1;
        end
        1: begin
          in_valid  = ($urandom_range(0, 3) != 0);
          ff_tx_rdy = ($urandom_range(0, 2) != 0);
          if (idle_run >= 3) in_valid = 1'b1;
        end
        default: begin
          in_valid  = 1'b1;
          ff_tx_rdy = !(ff_tx_wren && got_q.size() == 1 && stall_cnt < 3);
          if (!ff_tx_rdy) stall_cnt++;
        end
      endcase
      if (idx >= n) in_valid = 1'b0;
      idle_run  = in_valid ? 0 : idle_run + 1;
      in_data   = in_valid ? bytes_q[idx] : 8'($urandom);
      pkt_start = ($urandom_range(0, 7) == 0);
      pkt_len   = 11'($urandom_range(0, 2047));
      exp_wren   = 0;
      prev_stall = 0;
      if (in_valid && in_ready) begin
        idx++;
        exp_wren = (idx % 4 == 0) || (idx == n);
      end
      if (ff_tx_wren && ff_tx_rdy) begin
        got_q.push_back(cur);
        if (cur.eop || (abort_first && got_q.size() == 1)) done = 1;
      end else if (ff_tx_wren) begin
        prev_stall = 1;
        prev_w     = cur;
      end
      cyc++;
      @(negedge clk);
    end
    chk("pkt_timeout", 64'(done), 64'd1);
    pkt_start = 1'b0;
    in_valid  = 1'b0;
    if (abort_first) begin
      chk("first_word_count", 64'(got_q.size()), 64'd1);
      if (got_q.size() >= 1) chk("first_word", 64'(got_q[0]), 64'(exp_q[0]));
    end else begin
      chk("busy_fall", 64'(pkt_busy), 64'd0);
      chk("wren_idle", 64'(ff_tx_wren), 64'd0);
      chk("in_ready_idle", 64'(in_ready), 64'd0);
      if (mode == 0) chk("cycles", 64'(cyc), 64'(n + exp_q.size()));
      chk("word_count", 64'(got_q.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) begin
        if (i < got_q.size()) chk("word", 64'(got_q[i]), 64'(exp_q[i]));
      end
    end
  endtask

  initial begin
    int len;
    reset = 1'b1; pkt_start = 1'b1; pkt_len = 11'd5;
    in_data = '0; in_valid = 1'b0; ff_tx_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(pkt_busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_wren", 64'(ff_tx_wren), 64'd0);
    chk("rst_word", 64'(cur_word()), 64'd0);
    chk("rst_err", 64'(ff_tx_err), 64'd0);
    reset = 1'b0; pkt_start = 1'b0;
    // Zero length is ignored.
    pkt_len = 11'd0; pkt_start = 1'b1;
    @(negedge clk);
    pkt_start = 1'b0;
    chk("zero_len_ignored", 64'(pkt_busy), 64'd0);

    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_pkt(0, 0);
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    run_pkt(0, 0);
    bytes_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    run_pkt(2, 0);
    bytes_q = '{8'hAB};
    run_pkt(0, 0);

    // Reset just after the first word of a 12-byte packet.
    bytes_q.delete();
    for (int i = 0; i < 12; i++) bytes_q.push_back(8'(8'h30 + i));
    run_pkt(0, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_wren", 64'(ff_tx_wren), 64'd0);
    chk("midrst_busy", 64'(pkt_busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    bytes_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    run_pkt(0, 0);

    for (int p = 0; p < 14; p++) begin
      len = (p == 13) ? 2047 : int'($urandom_range(1, 64));
      bytes_q.delete();
      for (int i = 0; i < len; i++) bytes_q.push_back(8'($urandom));
      run_pkt((p % 4 == 3) ? 0 : 1, 0);
    end

`ifdef MAC_TX_ERR_EN
    begin
      int    idx, cyc;
      bit    done, last_err;
      word_t w0, w1;
      bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      got_q.delete();
      idx = 0; cyc = 0; done = 0; last_err = 0;
      @(negedge clk);
      pkt_len = 11'd8; pkt_start = 1'b1;
      @(negedge clk);
      pkt_start = 1'b0;
      ff_tx_rdy = 1'b1;
      while (!done && cyc < 400) begin
        if (ff_tx_wren) begin
          got_q.push_back(cur_word());
          if (ff_tx_eop) begin
            done = 1;
            last_err = ff_tx_err;
          end
        end
        in_valid = (idx < 5);
        in_data  = in_valid ? bytes_q[idx] : 8'h00;
        if (in_valid && in_ready) idx++;
        cyc++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      w0 = '{data: 32'h01020304, sop: 1'b1, eop: 1'b0, mod: 2'd0};
      w1 = '{data: 32'h05000000, sop: 1'b0, eop: 1'b1, mod: 2'd3};
      chk("uflow_done", 64'(done), 64'd1);
      chk("uflow_count", 64'(got_q.size()), 64'd2);
      if (got_q.size() == 2) begin
        chk("uflow_w0", 64'(got_q[0]), 64'(w0));
        chk("uflow_w1", 64'(got_q[1]), 64'(w1));
      end
      chk("uflow_err", 64'(last_err), 64'd1);
      chk("uflow_idle", 64'(pkt_busy), 64'd0);
      bytes_q = '{8'hD1, 8'hD2, 8'hD3};
      run_pkt(0, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
